// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver (start, DATA_BITS LSB first, optional parity, STOP_BITS)
//   feeding a show-ahead receive FIFO with a ready/valid byte output.
//
// Ports
//   CLOCK_50        in   system clock
//   rst_n           in   asynchronous active-low reset
//   rx              in   serial line, idles high, asynchronous to CLOCK_50
//   rx_data         out  head-of-FIFO data (DATA_BITS wide)
//   rx_valid        out  FIFO not empty
//   rx_ready        in   consumer pops when rx_valid && rx_ready
//   parity_err      out  parity flag stored with the head entry
//   frame_err       out  one-cycle pulse when a stop bit is sampled low
//   overflow        out  sticky, a frame was dropped on a full FIFO
//   clr_overflow    in   synchronous clear of overflow
//   fifo_count      out  current occupancy
//   rx_idle_timeout out  idle-line pulse, built only with UART_RX_IDLE_TIMEOUT_EN
//
// Optional feature macro: UART_RX_IDLE_TIMEOUT_EN
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line idle, waiting for a low level
// S_START  | half-bit wait, re-sample to reject glitches
// S_DATA   | sample DATA_BITS data bits, one per bit period
// S_PARITY | sample parity bit and latch the per-frame parity flag
// S_STOP   | sample STOP_BITS stop bits; on a low stop bit wait for high
// S_PUSH   | write {parity flag, data} into the FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_BITS    = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_idle_timeout
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_PUSH   = 3'd5;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tick;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          count_q;
  logic [EW-1:0]        last_q;
  logic [EW-1:0]        head;
  logic                 overflow_q;
  logic                 push_req, push, pop, full;

  assign rx_s = sync_q[1];
  assign tick = (cnt_q == '0);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    stop_bad_d  = stop_bad_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (rx_s) state_d = S_IDLE;
        else begin
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            perr_d  = 1'b0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          // error when the received bit differs from the expected parity bit
          perr_d  = rx_s ^ (^shift_q) ^ (PARITY_MODE == 2);
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_bad_q) begin
          // frame already discarded; hold off start detection until line is high
          if (rx_s) begin
            stop_bad_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          frame_err_d = 1'b1;
          stop_bad_d  = 1'b1;
          bit_d       = '0;
        end else if (bit_q == BW'(STOP_BITS - 1)) begin
          bit_d   = '0;
          state_d = S_PUSH;
        end else begin
          bit_d = bit_q + 1'b1;
          cnt_d = CW'(CLKS_PER_BIT - 1);
        end
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      stop_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      stop_bad_q  <= stop_bad_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO: a pop frees the slot for a simultaneous push when full
  assign pop      = (count_q != '0) && rx_ready;
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push_req = (state_q == S_PUSH);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_q] <= {perr_q, shift_q};
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (push_req && !push) overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // when empty the outputs keep showing the most recently popped entry
  assign head       = (count_q != '0) ? mem_q[rd_q] : last_q;
  assign rx_data    = head[DATA_BITS-1:0];
  assign parity_err = head[DATA_BITS];
  assign rx_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

`ifdef UART_RX_IDLE_TIMEOUT_EN
  localparam int TMO_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int TW         = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_armed_q;
  logic          tmo_pulse_q;

  // armed by a start bit, fires once after IDLE_BITS idle bit periods
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      tmo_armed_q <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= 1'b0;
      if (state_q == S_IDLE && !rx_s) begin
        tmo_cnt_q   <= TW'(TMO_CYCLES - 1);
        tmo_armed_q <= 1'b1;
      end else if (state_q == S_IDLE && tmo_armed_q) begin
        if (tmo_cnt_q == '0) begin
          tmo_armed_q <= 1'b0;
          tmo_pulse_q <= (count_q != '0);
        end else begin
          tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
      end
    end
  end

  assign rx_idle_timeout = tmo_pulse_q;
`else
  // IDLE_BITS only matters when the timeout is built; output is constant 0
  assign rx_idle_timeout = 1'b0 & (IDLE_BITS > 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Two receivers on one clock: instance A (8N1, 16-deep FIFO) and
//   instance B (8 data, even parity, 2 stop bits, 4-deep FIFO).
//   Frames are serialised by the bench; a queue per instance holds the
//   entries the receiver must deliver.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic       rx_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
  logic [7:0] data_a;
  logic       valid_a, perr_a, ferr_a, ovf_a, tmo_a;
  logic [4:0] cnt_a;

  logic       rx_b = 1'b1, rdy_b = 1'b0, clr_b = 1'b0;
  logic [7:0] data_b;
  logic       valid_b, perr_b, ferr_b, ovf_b, tmo_b;
  logic [2:0] cnt_b;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB)) u_dut_a (
    .CLOCK_50(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a),
    .clr_overflow(clr_a), .fifo_count(cnt_a), .rx_idle_timeout(tmo_a)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .CLOCK_50(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b),
    .clr_overflow(clr_b), .fifo_count(cnt_b), .rx_idle_timeout(tmo_b)
  );

  // reference model: {parity flag, data} entries per instance
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] last_v [2];
  logic       ovf_exp [2];
  int         ferr_exp [2];
  int         ferr_seen_a = 0, ferr_seen_b = 0;
  int         tmo_seen_a = 0, tmo_seen_b = 0;
  int         n_chk = 0, n_fail = 0;

  always @(negedge clk) begin
    if (ferr_a) ferr_seen_a <= ferr_seen_a + 1;
    if (ferr_b) ferr_seen_b <= ferr_seen_b + 1;
    if (tmo_a)  tmo_seen_a  <= tmo_seen_a + 1;
    if (tmo_b)  tmo_seen_b  <= tmo_seen_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int dut, input logic v);
    if (dut == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 2; i++) begin
      last_v[i]  = '0;
      ovf_exp[i] = 1'b0;
    end
  endtask

  // serialise one frame; B adds a parity bit and two stop bits
  task automatic send(input int dut, input logic [7:0] d, input logic pbit,
                      input logic good, input int gap);
    logic fr[$];
    logic [8:0] ent;
    int g;
    fr.push_back(1'b0);
    for (int i = 0; i < 8; i++) fr.push_back(d[i]);
    if (dut == 1) fr.push_back(pbit);
    repeat ((dut == 1) ? 2 : 1) fr.push_back(good);
    foreach (fr[i]) begin
      set_rx(dut, fr[i]);
      repeat (CPB) @(negedge clk);
    end
    set_rx(dut, 1'b1);
    if (!good) ferr_exp[dut]++;
    else begin
      ent = {(dut == 1) ? (pbit ^ (^d)) : 1'b0, d};
      if (dut == 0) begin
        if (q_a.size() < 16) q_a.push_back(ent); else ovf_exp[0] = 1'b1;
      end else begin
        if (q_b.size() < 4) q_b.push_back(ent); else ovf_exp[1] = 1'b1;
      end
    end
    g = (!good && gap < 1) ? 1 : gap;
    repeat (g * CPB) @(negedge clk);
  endtask

  task automatic check_state(input int dut);
    int n;
    logic [8:0] hd;
    n  = (dut == 0) ? q_a.size() : q_b.size();
    hd = last_v[dut];
    if (n > 0) hd = (dut == 0) ? q_a[0] : q_b[0];
    if (dut == 0) begin
      chk("a_count", cnt_a, n);
      chk("a_valid", valid_a, n > 0);
      chk("a_data", data_a, hd[7:0]);
      chk("a_perr", perr_a, hd[8]);
      chk("a_ovf", ovf_a, ovf_exp[0]);
      chk("a_ferr_pulses", ferr_seen_a, ferr_exp[0]);
    end else begin
      chk("b_count", cnt_b, n);
      chk("b_valid", valid_b, n > 0);
      chk("b_data", data_b, hd[7:0]);
      chk("b_perr", perr_b, hd[8]);
      chk("b_ovf", ovf_b, ovf_exp[1]);
      chk("b_ferr_pulses", ferr_seen_b, ferr_exp[1]);
    end
  endtask

  task automatic pop(input int dut);
    check_state(dut);
    if (dut == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    if (dut == 0 && q_a.size() > 0) last_v[0] = q_a.pop_front();
    if (dut == 1 && q_b.size() > 0) last_v[1] = q_b.pop_front();
    check_state(dut);
  endtask

  task automatic clear_ovf(input int dut);
    if (dut == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    ovf_exp[dut] = 1'b0;
    check_state(dut);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       good, pb;
    int         base;
    model_reset();
    ferr_exp[0] = 0;
    ferr_exp[1] = 0;

    // reset state
    repeat (CPB) @(negedge clk);
    check_state(0);
    check_state(1);
    chk("a_tmo_reset", tmo_a, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame and pop
    send(0, 8'hA5, 1'b0, 1'b1, 1);
    chk("a_first_data", data_a, 8'hA5);
    chk("a_first_count", cnt_a, 1);
    pop(0);
    pop(0);

    // back-to-back frames, no idle time
    send(0, 8'hA5, 1'b0, 1'b1, 0);
    send(0, 8'hBC, 1'b0, 1'b1, 1);
    chk("a_b2b_count", cnt_a, 2);
    pop(0);
    chk("a_b2b_second", data_a, 8'hBC);
    pop(0);

    // randomized traffic on A, including bad stop bits
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send(0, d, 1'b0, good, $urandom_range(0, 2));
      check_state(0);
      repeat ($urandom_range(0, 2)) pop(0);
    end
    for (int i = 0; i < 20 && q_a.size() > 0; i++) pop(0);

    // parity on B: 0x03 has even data parity, so a parity bit of 1 is wrong
    send(1, 8'h03, 1'b1, 1'b1, 1);
    chk("b_par_bad_flag", perr_b, 1);
    chk("b_par_bad_data", data_b, 8'h03);
    pop(1);
    send(1, 8'h03, 1'b0, 1'b1, 1);
    chk("b_par_ok_flag", perr_b, 0);
    pop(1);

    // framing error then a good frame
    send(1, 8'h55, 1'b0, 1'b0, 1);
    chk("b_ferr_count", cnt_b, 0);
    check_state(1);
    send(1, 8'h12, 1'b0, 1'b1, 1);
    chk("b_after_ferr", data_b, 8'h12);
    pop(1);

    // overflow on the 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send(1, d, ^d, 1'b1, 1);
    end
    chk("b_ovf_count", cnt_b, 4);
    chk("b_ovf_flag", ovf_b, 1);
    for (int i = 0; i < 4; i++) pop(1);
    clear_ovf(1);

    // randomized traffic on B
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      pb   = (^d) ^ ($urandom_range(0, 3) == 0);
      good = ($urandom_range(0, 4) != 0);
      send(1, d, pb, good, $urandom_range(0, 2));
      check_state(1);
      repeat ($urandom_range(0, 1)) pop(1);
      if ($urandom_range(0, 5) == 0) clear_ovf(1);
    end
    for (int i = 0; i < 8 && q_b.size() > 0; i++) pop(1);

    // glitch on A: 5 cycles low is rejected
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_state(0);
    send(0, 8'h3C, 1'b0, 1'b1, 1);
    chk("a_after_glitch", data_a, 8'h3C);

    `ifdef UART_RX_IDLE_TIMEOUT_EN
    base = tmo_seen_a;
    repeat (6 * CPB) @(negedge clk);
    chk("a_idle_timeout_pulses", tmo_seen_a - base, 1);
    `endif

    // reset in the middle of 0xF8 (bits 0,0,0 then ones); A holds 0x3C
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    repeat (CPB) @(negedge clk);
    repeat (CPB / 2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_state(0);
    check_state(1);
    repeat (CPB / 2) @(negedge clk);
    repeat (CPB) @(negedge clk);
    rx_a = 1'b1;
    rst_n = 1'b1;
    repeat (7 * CPB) @(negedge clk);
    check_state(0);
    send(0, 8'h81, 1'b0, 1'b1, 1);
    pop(0);

    base = tmo_seen_b;
    chk("b_tmo_unused", tmo_seen_b - base, 0);
    `ifndef UART_RX_IDLE_TIMEOUT_EN
    chk("a_tmo_never", tmo_seen_a, 0);
    `endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an integrated receive FIFO, one serial input line and one ready/valid byte output.
- Successor to the fixed 8N1 receiver on the GPIO RX pin.
- Adds configurable data width, parity, stop-bit count, bit timing and buffering depth, plus error reporting.
- Sits between the GPIO RX pin and the LED/display/command logic in top_level.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit: 50 MHz / 115200 baud, so one bit = 8680 ns.
- DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
- PARITY_MODE, 0, parity: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- FIFO_DEPTH, 16, receive FIFO entries, power of two, minimum 2.
- IDLE_BITS, 4, idle bit-periods before timeout (used only with the optional feature).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset (driven from KEY[0]).
- rx  in  1  serial line; idles high; asynchronous to CLOCK_50.
- rx_data  out  DATA_BITS  head-of-FIFO data.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- parity_err  out  1  head-of-FIFO entry carries a parity error (stored per entry).
- frame_err  out  1  one-cycle pulse: a stop bit sampled low.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_overflow  in  1  synchronous clear of overflow.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- rx_idle_timeout  out  1  timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous): FSM in IDLE; FIFO empty; all counters 0.
  - Outputs: rx_valid=0, rx_data=0, parity_err=0, frame_err=0, overflow=0, fifo_count=0, rx_idle_timeout=0.
  - Synchroniser flops reset to 1.
- Input sync: rx passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH.
  - IDLE: on synchronised rx=0, load bit counter and go to START.
  - START: at CLKS_PER_BIT/2 cycles re-sample. If rx=0, go to DATA. If rx=1, treat as a glitch and return to IDLE with nothing stored.
  - DATA: sample every CLKS_PER_BIT cycles, shift LSB first, DATA_BITS samples. Then go to PARITY if PARITY_MODE≠0, otherwise STOP.
  - PARITY: one sample; compare against XOR of the data bits (even) or its inverse (odd). The result is latched as the per-frame parity flag.
  - STOP: STOP_BITS samples, one per CLKS_PER_BIT.
    - Any stop sample = 0: frame_err pulses 1 cycle, the frame is discarded, and the FSM waits in STOP until rx=1 before entering IDLE.
    - Otherwise go to PUSH.
  - PUSH: one cycle. Write {parity flag, data} into the FIFO. If the FIFO is full, drop the frame and set overflow. Return to IDLE.
- Latency: a frame is visible on rx_valid 1 cycle after PUSH, i.e. about STOP_BITS×CLKS_PER_BIT + 4 cycles after the middle of the last data bit.
- Next start bit: detection in IDLE resumes immediately after PUSH. Back-to-back frames with zero idle time are received.
- FIFO:
  - Show-ahead: rx_data and parity_err reflect the head entry whenever rx_valid=1. When empty, they hold their last value.
  - Pop on rx_valid && rx_ready.
  - Push and pop in the same cycle when full: the pop occurs and the push succeeds, with no overflow.
  - Push and pop in the same cycle when empty: the push occurs and there is no pop.
  - fifo_count is exact every cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: stays 1 until clr_overflow or reset. If clr_overflow and a new overflow occur in the same cycle, overflow stays 1.
- rx_ready while rx_valid=0 is ignored.
- Unused upper bits of rx_data do not exist; the width is exactly DATA_BITS.

Optional Feature:
- Macro: UART_RX_IDLE_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in IDLE and rx=1.
  - When it reaches IDLE_BITS×CLKS_PER_BIT with fifo_count>0, rx_idle_timeout pulses high for 1 cycle.
  - The counter re-arms only after the next start bit.
  - Purpose: message delimiting for command packets.
- Not defined: no counter logic is built; rx_idle_timeout is tied to 0.

Test Plan:
- Defaults: reset low 8680 ns, release; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1) at 8680 ns/bit.
  - Required: rx_valid=1, rx_data=8'hA5, parity_err=0, fifo_count=1.
  - Pulse rx_ready for 1 cycle: rx_valid=0, fifo_count=0.
- Back-to-back: 0xA5 then 0xBC with zero idle, rx_ready=0.
  - Required: fifo_count=2, head 0xA5.
  - After one pop: head 0xBC.
- PARITY_MODE=1: send 0x03 with parity bit 1.
  - Required: parity_err=1, data 0x03 still stored.
  - Then send 0x03 with parity bit 0: parity_err=0 for that entry.
- Framing: send 0x55 with stop bit 0, then return high.
  - Required: frame_err pulses 1 cycle, fifo_count unchanged.
  - Next valid frame 0x12 is received correctly.
- FIFO_DEPTH=4, rx_ready=0: send 5 frames 0x01..0x05.
  - Required: fifo_count=4, overflow=1, contents pop as 0x01..0x04.
  - clr_overflow then clears overflow.
- Glitch and reset: rx low for 100 ns then high.
  - Required: no entry, FSM back to IDLE.
  - Assert rst_n low mid-frame: all outputs 0 immediately; the remaining bits of that frame produce no entry.
  - With UART_RX_IDLE_TIMEOUT_EN: one frame followed by 4 idle bit-times gives exactly one rx_idle_timeout pulse.
